// File: rtl/regfile_wb_queue_if.sv
// Handshake and read-port bundle between a write producer, the write-back queue and the regfile.
interface regfile_wb_queue_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUMREGS = 8,
  parameter int unsigned DEPTH   = 4
);
  localparam int unsigned AW = (NUMREGS > 1) ? $clog2(NUMREGS) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             i_wr_valid;
  logic             o_wr_ready;
  logic [AW-1:0]    i_wr_addr;
  logic [WIDTH-1:0] i_wr_data;
  logic             i_drain_en;
  logic             o_rf_write;
  logic [AW-1:0]    o_rf_addrw;
  logic [WIDTH-1:0] o_rf_data;
  logic [AW-1:0]    i_rdx_addr;
  logic [AW-1:0]    i_rdy_addr;
  logic [WIDTH-1:0] i_rdx_rf;
  logic [WIDTH-1:0] i_rdy_rf;
  logic [WIDTH-1:0] o_rdx_data;
  logic [WIDTH-1:0] o_rdy_data;
  logic             o_rdx_hit;
  logic             o_rdy_hit;
  logic [CW-1:0]    o_count;

  modport slave (
    input  i_wr_valid, i_wr_addr, i_wr_data, i_drain_en,
    input  i_rdx_addr, i_rdy_addr, i_rdx_rf, i_rdy_rf,
    output o_wr_ready, o_rf_write, o_rf_addrw, o_rf_data,
    output o_rdx_data, o_rdy_data, o_rdx_hit, o_rdy_hit, o_count
  );

  modport master (
    output i_wr_valid, i_wr_addr, i_wr_data, i_drain_en,
    output i_rdx_addr, i_rdy_addr, i_rdx_rf, i_rdy_rf,
    input  o_wr_ready, o_rf_write, o_rf_addrw, o_rf_data,
    input  o_rdx_data, o_rdy_data, o_rdx_hit, o_rdy_hit, o_count
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// Pending register-write FIFO that drains into the regfile write port and forwards
// the youngest pending value to two read ports.
module regfile_wb_queue #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUMREGS = 8,
  parameter int unsigned DEPTH   = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  regfile_wb_queue_if.slave bus
);
  localparam int unsigned AW = (NUMREGS > 1) ? $clog2(NUMREGS) : 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;

  logic             not_empty;
  logic             push;
  logic             pop;

  logic [WIDTH-1:0] x_data;
  logic [WIDTH-1:0] y_data;
  logic             x_hit;
  logic             y_hit;
  logic [PW-1:0]    idx;

  // Ready comes from the registered count only, never from this cycle's valid/drain.
  assign not_empty = (count_q != '0);
  assign push      = bus.i_wr_valid && bus.o_wr_ready;
  assign pop       = not_empty && bus.i_drain_en;

  assign bus.o_wr_ready = (count_q < CW'(DEPTH));
  assign bus.o_rf_write = pop;
  assign bus.o_rf_addrw = not_empty ? addr_q[head_q] : '0;
  assign bus.o_rf_data  = not_empty ? data_q[head_q] : '0;
  assign bus.o_count    = count_q;

  // Entry storage and pointers; reset wipes everything so no stale write survives.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[tail_q] <= bus.i_wr_addr;
        data_q[tail_q] <= bus.i_wr_data;
        tail_q         <= tail_q + PW'(1);
      end
      if (pop) begin
        head_q <= head_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    x_data = bus.i_rdx_rf;
    y_data = bus.i_rdy_rf;
    x_hit  = 1'b0;
    y_hit  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (addr_q[idx] == bus.i_rdx_addr) begin
          x_data = data_q[idx];
          x_hit  = 1'b1;
        end
        if (addr_q[idx] == bus.i_rdy_addr) begin
          y_data = data_q[idx];
          y_hit  = 1'b1;
        end
      end
    end
  end

  assign bus.o_rdx_data = x_data;
  assign bus.o_rdy_data = y_data;
  assign bus.o_rdx_hit  = x_hit;
  assign bus.o_rdy_hit  = y_hit;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed and random bench for regfile_wb_queue with a write-order scoreboard and regfile model.
module tb_regfile_wb_queue;
  localparam int unsigned W  = 16;
  localparam int unsigned N  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned AW = 3;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } ent_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   arch_chk;

  ent_t        m_q [$];
  logic [W-1:0] rf_model [N];
  logic [W-1:0] arch     [N];

  regfile_wb_queue_if #(.WIDTH(W), .NUMREGS(N), .DEPTH(D)) bus ();

  regfile_wb_queue #(.WIDTH(W), .NUMREGS(N), .DEPTH(D)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_reads(input logic [AW-1:0] xa, input logic [AW-1:0] ya);
    bus.i_rdx_addr = xa;
    bus.i_rdy_addr = ya;
    bus.i_rdx_rf   = rf_model[xa];
    bus.i_rdy_rf   = rf_model[ya];
  endtask

  task automatic set_wr(input logic v, input logic [AW-1:0] a, input logic [W-1:0] d);
    bus.i_wr_valid = v;
    bus.i_wr_addr  = a;
    bus.i_wr_data  = d;
  endtask

  // Compare one cycle's outputs against the model, then advance the model.
  task automatic check_cycle();
    logic         exp_wr;
    logic         exp_push;
    logic [W-1:0] exd;
    logic [W-1:0] eyd;
    logic         exh;
    logic         eyh;
    ent_t         e;
    exp_wr   = (m_q.size() != 0) && bus.i_drain_en;
    exp_push = bus.i_wr_valid && (m_q.size() < D);
    chk("ready", 32'(bus.o_wr_ready), 32'(m_q.size() < D));
    chk("count", 32'(bus.o_count), 32'(m_q.size()));
    chk("rf_write", 32'(bus.o_rf_write), 32'(exp_wr));
    if (m_q.size() != 0) begin
      chk("rf_addrw", 32'(bus.o_rf_addrw), 32'(m_q[0].a));
      chk("rf_data", 32'(bus.o_rf_data), 32'(m_q[0].d));
    end else begin
      chk("rf_addrw_idle", 32'(bus.o_rf_addrw), 32'd0);
      chk("rf_data_idle", 32'(bus.o_rf_data), 32'd0);
    end
    exd = bus.i_rdx_rf; exh = 1'b0;
    eyd = bus.i_rdy_rf; eyh = 1'b0;
    foreach (m_q[k]) begin
      if (m_q[k].a == bus.i_rdx_addr) begin exd = m_q[k].d; exh = 1'b1; end
      if (m_q[k].a == bus.i_rdy_addr) begin eyd = m_q[k].d; eyh = 1'b1; end
    end
    chk("rdx_data", 32'(bus.o_rdx_data), 32'(exd));
    chk("rdx_hit", 32'(bus.o_rdx_hit), 32'(exh));
    chk("rdy_data", 32'(bus.o_rdy_data), 32'(eyd));
    chk("rdy_hit", 32'(bus.o_rdy_hit), 32'(eyh));
    if (arch_chk) begin
      chk("arch_x", 32'(bus.o_rdx_data), 32'(arch[bus.i_rdx_addr]));
      chk("arch_y", 32'(bus.o_rdy_data), 32'(arch[bus.i_rdy_addr]));
    end
    if (exp_wr) begin
      e = m_q.pop_front();
      rf_model[e.a] = e.d;
    end
    if (exp_push) begin
      e.a = bus.i_wr_addr;
      e.d = bus.i_wr_data;
      m_q.push_back(e);
      arch[e.a] = e.d;
    end
  endtask

  // Called just after a rising edge with inputs already driven.
  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    arch_chk = 1'b0;
    for (int i = 0; i < N; i++) begin
      rf_model[i] = '0;
      arch[i]     = '0;
    end
    rst_n = 1'b0;
    set_wr(1'b1, 3'd2, 16'hDEAD);
    bus.i_drain_en = 1'b1;
    drive_reads(3'd2, 3'd3);

    // Reset state while held in reset, with traffic presented.
    #12;
    chk("rst_ready", 32'(bus.o_wr_ready), 32'd1);
    chk("rst_count", 32'(bus.o_count), 32'd0);
    chk("rst_rf_write", 32'(bus.o_rf_write), 32'd0);
    chk("rst_rf_addrw", 32'(bus.o_rf_addrw), 32'd0);
    chk("rst_rf_data", 32'(bus.o_rf_data), 32'd0);
    chk("rst_rdx_hit", 32'(bus.o_rdx_hit), 32'd0);
    chk("rst_rdy_hit", 32'(bus.o_rdy_hit), 32'd0);
    set_wr(1'b0, '0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Single write: no same-cycle bypass, drains on the next edge.
    set_wr(1'b1, 3'd3, 16'h1234);
    drive_reads(3'd3, 3'd0);
    tick();
    set_wr(1'b0, '0, '0);
    drive_reads(3'd3, 3'd0);
    tick();
    tick();

    // Fill and stall, fifth write held until space opens.
    bus.i_drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_wr(1'b1, AW'(i), 16'(16'hA0 + i));
      drive_reads(AW'(i), 3'd4);
      tick();
    end
    set_wr(1'b1, 3'd5, 16'hA5);
    tick();
    tick();
    bus.i_drain_en = 1'b1;
    tick();
    tick();
    set_wr(1'b0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      drive_reads(AW'(i + 1), 3'd5);
      tick();
    end

    // Forwarding picks the youngest pending entry.
    bus.i_drain_en = 1'b0;
    set_wr(1'b1, 3'd5, 16'h0011);
    tick();
    set_wr(1'b1, 3'd5, 16'h0022);
    tick();
    set_wr(1'b0, '0, '0);
    bus.i_rdx_addr = 3'd5;
    bus.i_rdx_rf   = 16'hFFFF;
    bus.i_rdy_addr = 3'd6;
    bus.i_rdy_rf   = 16'h5A5A;
    tick();
    chk("fwd_x_0022", 32'(bus.o_rdx_data), 32'h0022);
    chk("fwd_y_rf", 32'(bus.o_rdy_data), 32'h5A5A);
    bus.i_drain_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_reads(3'd5, 3'd6);
      tick();
    end

    // Simultaneous push/pop at count 2 across pointer wrap.
    bus.i_drain_en = 1'b0;
    set_wr(1'b1, 3'd1, 16'h00B1);
    tick();
    set_wr(1'b1, 3'd2, 16'h00B2);
    tick();
    bus.i_drain_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_wr(1'b1, AW'(i + 3), 16'(16'hC0 + i));
      drive_reads(AW'(i + 1), AW'(i + 3));
      tick();
      chk("pp_count", 32'(bus.o_count), 32'd2);
    end
    set_wr(1'b0, '0, '0);
    tick();
    tick();
    tick();

    // Asynchronous reset mid-operation with three pending entries.
    bus.i_drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_wr(1'b1, AW'(i + 2), 16'(16'hE0 + i));
      tick();
    end
    set_wr(1'b0, '0, '0);
    bus.i_drain_en = 1'b1;
    drive_reads(3'd2, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(bus.o_count), 32'd0);
    chk("mid_rst_rf_write", 32'(bus.o_rf_write), 32'd0);
    chk("mid_rst_ready", 32'(bus.o_wr_ready), 32'd1);
    chk("mid_rst_rdx_hit", 32'(bus.o_rdx_hit), 32'd0);
    m_q.delete();
    for (int i = 0; i < N; i++) arch[i] = rf_model[i];
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Random traffic against the architectural regfile model.
    arch_chk = 1'b1;
    for (int i = 0; i < 400; i++) begin
      set_wr(1'($urandom_range(0, 1)), AW'($urandom_range(0, N - 1)), W'($urandom));
      bus.i_drain_en = ($urandom_range(0, 2) != 0);
      drive_reads(AW'($urandom_range(0, N - 1)), AW'($urandom_range(0, N - 1)));
      tick();
    end
    set_wr(1'b0, '0, '0);
    bus.i_drain_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_reads(AW'(i), AW'(i + 1));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
